fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_watchdog.sv | 36 +++
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: state encoding, fault codes,
// reset instruction and the opcode constants also used by the controller.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_e;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/fetch_unit_watchdog.sv
// Fetch wait-state counter; pulses timeout on the last permitted FETCH cycle
// that still has no memory response.
module fetch_watchdog #(
    parameter int unsigned MAX_WAIT = 16,
    localparam int unsigned CW = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic valid,
    output logic timeout
);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;

    always_comb begin
        timeout    = enable && !valid && (wait_cnt_q == CW'(MAX_WAIT - 1));
        wait_cnt_d = wait_cnt_q;
        if (clear || (enable && valid)) begin
            wait_cnt_d = '0;
        end else if (enable && !timeout) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencing stage: fetches over a valid handshake,
// presents each instruction for one EXEC cycle, then picks the next PC or halts.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     MAX_WAIT = 16,
    parameter logic [31:0]     NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            next_pc_sel,
    input  logic [XLEN-1:0] jb_pc,
    input  logic            ecall_sig,
    input  logic [31:0]     im_rdata,
    input  logic            im_valid,
    output logic            im_req,
    output logic [XLEN-1:0] im_addr,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     inst,
    output logic            inst_valid,
    output logic            halted,
    output logic [1:0]      fault,
    output logic [XLEN-1:0] instret
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic            halted_q, halted_d;
    logic [1:0]      fault_q, fault_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic [XLEN-1:0] target;
    logic            timeout;

    fetch_watchdog #(
        .MAX_WAIT(MAX_WAIT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q == ST_BOOT),
        .enable (state_q == ST_FETCH),
        .valid  (im_valid),
        .timeout(timeout)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        instret_d  = instret_q;
        im_req     = 1'b0;
        inst_valid = 1'b0;
        target     = jb_pc & ~XLEN'(1);

        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                im_req = 1'b1;
                // A response on the timeout cycle still counts as a good fetch.
                if (im_valid) begin
                    inst_d  = im_rdata;
                    state_d = ST_EXEC;
                end else if (timeout) begin
                    fault_d  = FAULT_TIMEOUT;
                    halted_d = 1'b1;
                    inst_d   = NOP_INST;
                    state_d  = ST_HALT;
                end
            end
            ST_EXEC: begin
                inst_valid = 1'b1;
                if (ecall_sig) begin
                    instret_d = instret_q + XLEN'(1);
                    halted_d  = 1'b1;
                    state_d   = ST_HALT;
                end else if (next_pc_sel) begin
                    if (target[1]) begin
                        fault_d  = FAULT_MISALIGN;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        pc_d      = target;
                        instret_d = instret_q + XLEN'(1);
                        state_d   = ST_FETCH;
                    end
                end else begin
                    pc_d      = pc_q + XLEN'(4);
                    instret_d = instret_q + XLEN'(1);
                    state_d   = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            inst_q    <= NOP_INST;
            halted_q  <= 1'b0;
            fault_q   <= FAULT_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            halted_q  <= halted_d;
            fault_q   <= fault_d;
            instret_q <= instret_d;
        end
    end

    assign im_addr = pc_q;
    assign pc      = pc_q;
    assign inst    = inst_q;
    assign halted  = halted_q;
    assign fault   = fault_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes expected fetch/exec records,
// a negedge monitor pops and compares; a second instance covers the timeout path.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] instret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        next_pc_sel = 1'b0;
    logic [31:0] jb_pc = '0;
    logic        ecall_sig = 1'b0;
    logic [31:0] im_rdata = '0;
    logic        im_valid = 1'b0;
    logic        im_req, inst_valid, halted;
    logic [31:0] im_addr, pc, inst, instret;
    logic [1:0]  fault;

    logic        t_rst_n = 1'b0;
    logic        t_next_pc_sel = 1'b0;
    logic [31:0] t_jb_pc = '0;
    logic        t_ecall_sig = 1'b0;
    logic [31:0] t_im_rdata = '0;
    logic        t_im_valid = 1'b0;
    logic        t_im_req, t_inst_valid, t_halted;
    logic [31:0] t_im_addr, t_pc, t_inst, t_instret;
    logic [1:0]  t_fault;

    int checks = 0;
    int passed = 0;

    logic [31:0] fetch_q[$];
    exp_t        exec_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_instret;
    logic [1:0]  model_fault;
    logic        model_halted;
    logic        prev_iv = 1'b0;

    fetch_unit #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .MAX_WAIT(16), .NOP_INST(32'h0000_0013)
    ) dut (
        .clk(clk), .rst_n(rst_n), .next_pc_sel(next_pc_sel), .jb_pc(jb_pc),
        .ecall_sig(ecall_sig), .im_rdata(im_rdata), .im_valid(im_valid),
        .im_req(im_req), .im_addr(im_addr), .pc(pc), .inst(inst),
        .inst_valid(inst_valid), .halted(halted), .fault(fault), .instret(instret)
    );

    fetch_unit #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .MAX_WAIT(4), .NOP_INST(32'h0000_0013)
    ) dut_t (
        .clk(clk), .rst_n(t_rst_n), .next_pc_sel(t_next_pc_sel), .jb_pc(t_jb_pc),
        .ecall_sig(t_ecall_sig), .im_rdata(t_im_rdata), .im_valid(t_im_valid),
        .im_req(t_im_req), .im_addr(t_im_addr), .pc(t_pc), .inst(t_inst),
        .inst_valid(t_inst_valid), .halted(t_halted), .fault(t_fault), .instret(t_instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (im_req && im_valid) begin
                if (fetch_q.size() == 0) chk("fetch_unexpected", 32'd1, 32'd0);
                else chk("fetch_addr", im_addr, fetch_q.pop_front());
            end
            if (inst_valid) begin
                chk("exec_single_cycle", {31'd0, prev_iv}, 32'd0);
                chk("exec_no_req", {31'd0, im_req}, 32'd0);
                if (exec_q.size() == 0) begin
                    chk("exec_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exec_q.pop_front();
                    chk("exec_pc", pc, e.pc);
                    chk("exec_inst", inst, e.inst);
                    chk("exec_instret", instret, e.instret);
                end
            end
        end
        prev_iv <= inst_valid;
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (im_req) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("wait_im_req_timeout", {31'd0, im_req}, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        im_valid = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_im_req", {31'd0, im_req}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", {30'd0, fault}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        im_valid = 1'b0;
        rst_n = 1'b1;
        model_pc = 32'h0;
        model_instret = 32'h0;
        model_fault = 2'b00;
        model_halted = 1'b0;
        fetch_q.delete();
        exec_q.delete();
    endtask

    // One instruction: wait for the fetch, respond after dly wait states, then drive EXEC controls.
    task automatic do_instr(input int unsigned dly, input logic [31:0] data,
                            input logic sel, input logic [31:0] jb, input logic ec);
        bit ok;
        logic [31:0] tgt;
        wait_req(ok);
        if (!ok) return;
        fetch_q.push_back(model_pc);
        exec_q.push_back('{pc: model_pc, inst: data, instret: model_instret});
        for (int unsigned i = 0; i < dly; i++) begin
            chk("wait_req_held", {31'd0, im_req}, 32'd1);
            chk("wait_no_fault", {30'd0, fault}, 32'd0);
            im_rdata = $urandom;
            @(posedge clk); #1;
        end
        im_valid = 1'b1;
        im_rdata = data;
        @(posedge clk); #1;
        im_valid = 1'b0;
        im_rdata = $urandom;
        next_pc_sel = sel;
        jb_pc = jb;
        ecall_sig = ec;
        @(posedge clk); #1;
        next_pc_sel = $urandom_range(1);
        jb_pc = $urandom;
        ecall_sig = $urandom_range(1);
        if (ec) begin
            model_instret = model_instret + 1;
            model_halted = 1'b1;
        end else if (sel) begin
            tgt = jb & 32'hFFFF_FFFE;
            if (tgt[1]) begin
                model_fault = 2'b01;
                model_halted = 1'b1;
            end else begin
                model_pc = tgt;
                model_instret = model_instret + 1;
            end
        end else begin
            model_pc = model_pc + 32'd4;
            model_instret = model_instret + 1;
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_pc"}, pc, model_pc);
        chk({tag, "_instret"}, instret, model_instret);
        chk({tag, "_fault"}, {30'd0, fault}, {30'd0, model_fault});
        chk({tag, "_halted"}, {31'd0, halted}, {31'd0, model_halted});
    endtask

    initial begin
        bit ok;
        logic [31:0] d;

        // Sequential zero-wait fetches, then a delayed response.
        do_reset();
        for (int i = 0; i < 3; i++) do_instr(0, $urandom, 1'b0, 32'h0, 1'b0);
        chk("seq_instret3", instret, 32'd3);
        chk("seq_pc", pc, 32'hC);
        do_instr(5, 32'hCAFE_0001, 1'b0, 32'h0, 1'b0);

        // Jump with bit0 set, then a misaligned target.
        do_instr(0, $urandom, 1'b1, 32'h0000_0101, 1'b0);
        chk("jump_pc", pc, 32'h0000_0100);
        do_instr(1, $urandom, 1'b1, 32'h0000_0106, 1'b0);
        chk("misalign_fault", {30'd0, fault}, 32'd1);
        chk("misalign_pc", pc, 32'h0000_0100);
        chk_state("misalign");
        chk("misalign_req", {31'd0, im_req}, 32'd0);

        // Randomised run, then ecall together with next_pc_sel.
        do_reset();
        for (int i = 0; i < 30; i++)
            do_instr($urandom_range(6), $urandom, 1'($urandom_range(1)),
                     $urandom & 32'hFFFF_FFFD, 1'b0);
        chk_state("random");
        d = $urandom;
        do_instr($urandom_range(3), d, 1'b1, $urandom, 1'b1);
        chk_state("ecall");
        chk("ecall_req", {31'd0, im_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            im_valid = 1'b1;
            im_rdata = $urandom;
            @(posedge clk); #1;
            im_valid = 1'b0;
            @(posedge clk); #1;
            chk_state("halt_frozen");
            chk("halt_inst", inst, d);
            chk("halt_req", {31'd0, im_req}, 32'd0);
            chk("halt_iv", {31'd0, inst_valid}, 32'd0);
        end

        // PC wrap from 0xFFFF_FFFC, then reset mid-fetch with im_valid on the same edge.
        do_reset();
        do_instr(0, $urandom, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("pre_wrap_pc", pc, 32'hFFFF_FFFC);
        do_instr(1, $urandom, 1'b0, 32'h0, 1'b0);
        chk("wrap_pc", pc, 32'h0);
        do_instr(0, $urandom, 1'b0, 32'h0, 1'b0);
        wait_req(ok);
        im_valid = 1'b1;
        im_rdata = 32'h1234_5678;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        im_valid = 1'b0;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instret", instret, 32'd0);
        chk("midrst_inst", inst, 32'h0000_0013);
        chk("midrst_req_boot", {31'd0, im_req}, 32'd0);
        chk("midrst_iv", {31'd0, inst_valid}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_req_fetch", {31'd0, im_req}, 32'd1);

        // Timeout instance (MAX_WAIT=4): response on the last allowed cycle wins.
        @(posedge clk); #1;
        t_rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("t_req_held", {31'd0, t_im_req}, 32'd1);
            @(posedge clk); #1;
        end
        d = $urandom | 32'h1;
        t_im_valid = 1'b1;
        t_im_rdata = d;
        @(posedge clk); #1;
        t_im_valid = 1'b0;
        chk("t_edge_fault", {30'd0, t_fault}, 32'd0);
        chk("t_edge_iv", {31'd0, t_inst_valid}, 32'd1);
        chk("t_edge_inst", t_inst, d);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("t_wait_req", {31'd0, t_im_req}, 32'd1);
            chk("t_wait_fault", {30'd0, t_fault}, 32'd0);
            @(posedge clk); #1;
        end
        chk("t_timeout_fault", {30'd0, t_fault}, 32'd2);
        chk("t_timeout_halted", {31'd0, t_halted}, 32'd1);
        chk("t_timeout_inst", t_inst, 32'h0000_0013);
        chk("t_timeout_req", {31'd0, t_im_req}, 32'd0);
        chk("t_timeout_pc", t_pc, 32'h4);
        chk("t_timeout_instret", t_instret, 32'd1);

        chk("fetch_q_drained", fetch_q.size(), 32'd0);
        chk("exec_q_drained", exec_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
